// File: rtl/pulse_stretcher_if.sv
// rtl/pulse_stretcher_if.sv - event input and stretched-level output bundle for pulse_stretcher
interface pulse_stretcher_if #(
  parameter int PEND_W = 3
);
  logic              din;
  logic              dout;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  // Event source side: drives din, observes the stretched output and status
  modport master (
    output din,
    input  dout,
    input  busy,
    input  pending,
    input  overflow
  );

  // Stretcher side
  modport slave (
    input  din,
    output dout,
    output busy,
    output pending,
    output overflow
  );
endinterface

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches single-cycle events into fixed-length level pulses with a pending queue
module pulse_stretcher #(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 2,
  parameter int PEND_W      = 3
) (
  input logic           clk,
  input logic           reset,
  pulse_stretcher_if.slave bus
);

  localparam int CNT_MAX = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int CNT_W   = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic               ovf_q, ovf_d;
  logic               dout_q, busy_q;
  logic               queue_in;

  // Next-state, counter and pending-queue decisions
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    ovf_d    = 1'b0;
    queue_in = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.din) begin
          state_d = HIGH;
          cnt_d   = HIGH_LOAD;
        end
      end

      HIGH: begin
        queue_in = bus.din;
        if (cnt_q == CNT_ZERO) begin
          state_d = GAP;
          cnt_d   = LOW_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      GAP: begin
        if (cnt_q == CNT_ZERO) begin
          if (pend_q != '0) begin
            // Replay the oldest queued event; a simultaneous new event
            // takes its slot so the count is unchanged and nothing drops.
            state_d = HIGH;
            cnt_d   = HIGH_LOAD;
            if (!bus.din) begin
              pend_d = pend_q - PEND_ONE;
            end
          end else if (bus.din) begin
            state_d = HIGH;
            cnt_d   = HIGH_LOAD;
          end else begin
            state_d = IDLE;
            cnt_d   = CNT_ZERO;
          end
        end else begin
          queue_in = bus.din;
          cnt_d    = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // Events arriving mid-pulse are queued until the counter saturates
    if (queue_in) begin
      if (pend_q != PEND_MAX) begin
        pend_d = pend_q + PEND_ONE;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // State register with registered copies of every output
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      dout_q  <= (state_d == HIGH);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.dout     = dout_q;
  assign bus.busy     = busy_q;
  assign bus.pending  = pend_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - self-checking bench for pulse_stretcher
module tb_pulse_stretcher;

  localparam int LC   = 2;
  localparam int PW   = 3;
  localparam int HA   = 4;
  localparam int HB   = 16;
  localparam int PMAX = 7;
  localparam int NV   = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ra, rb;

  pulse_stretcher_if #(.PEND_W(PW)) ifa ();
  pulse_stretcher_if #(.PEND_W(PW)) ifb ();

  pulse_stretcher #(.HIGH_CYCLES(HA), .LOW_CYCLES(LC), .PEND_W(PW)) dut_a (
    .clk   (clk),
    .reset (ra),
    .bus   (ifa)
  );

  pulse_stretcher #(.HIGH_CYCLES(HB), .LOW_CYCLES(LC), .PEND_W(PW)) dut_b (
    .clk   (clk),
    .reset (rb),
    .bus   (ifb)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Rising-edge detector fed by dut_a's output (registered, one cycle late)
  logic da_q = 1'b0;
  logic det  = 1'b0;
  always @(posedge clk) begin
    da_q <= ifa.dout;
    det  <= ifa.dout & ~da_q;
  end

  // Inputs as seen at the most recent active edge
  logic dq[2];
  logic rq[2];
  bit   edged = 1'b0;
  always @(posedge clk) begin
    dq[0] <= ifa.din;
    rq[0] <= ra;
    dq[1] <= ifb.din;
    rq[1] <= rb;
    edged <= 1'b1;
  end

  // Timeline model: a pulse started at edge s is high for edges s..s+H-1,
  // low through s+H+L-1, and the next start is decided at edge s+H+L.
  int m_act[2];
  int m_s[2];
  int m_t[2];
  int m_pend[2];
  int m_ovf[2];
  int m_ovf_cnt[2];
  bit m_valid[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_s[i] = 0; m_t[i] = 0; m_pend[i] = 0;
      m_ovf[i] = 0; m_ovf_cnt[i] = 0; m_valid[i] = 1'b0;
    end
  end

  function automatic void mstep(input int i, input logic d, input logic r, input int h);
    m_t[i]   = m_t[i] + 1;
    m_ovf[i] = 0;
    if (r) begin
      m_valid[i] = 1'b1;
      m_act[i]   = 0;
      m_pend[i]  = 0;
    end else if (m_act[i] == 0) begin
      if (d) begin
        m_act[i] = 1;
        m_s[i]   = m_t[i];
      end
    end else if (m_t[i] == m_s[i] + h + LC) begin
      if (m_pend[i] > 0) begin
        m_s[i] = m_t[i];
        if (!d) m_pend[i] = m_pend[i] - 1;
      end else if (d) begin
        m_s[i] = m_t[i];
      end else begin
        m_act[i] = 0;
      end
    end else if (d) begin
      if (m_pend[i] < PMAX) begin
        m_pend[i] = m_pend[i] + 1;
      end else begin
        m_ovf[i]     = 1;
        m_ovf_cnt[i] = m_ovf_cnt[i] + 1;
      end
    end
  endfunction

  function automatic int mexp(input int i, input int h);
    int dv;
    dv = (m_act[i] != 0 && (m_t[i] - m_s[i]) < h) ? 1 : 0;
    return (dv << 5) | (m_act[i] << 4) | (m_pend[i] << 1) | m_ovf[i];
  endfunction

  // Every-cycle comparison of both DUTs against the model, packed {dout,busy,pending,overflow}
  always @(negedge clk) begin
    if (edged) begin
      mstep(0, dq[0], rq[0], HA);
      mstep(1, dq[1], rq[1], HB);
      if (m_valid[0])
        chk($sformatf("a_cyc%0d", m_t[0]), int'({ifa.dout, ifa.busy, ifa.pending, ifa.overflow}), mexp(0, HA));
      if (m_valid[1])
        chk($sformatf("b_cyc%0d", m_t[1]), int'({ifb.dout, ifb.busy, ifb.pending, ifb.overflow}), mexp(1, HB));
    end
  end

  logic din_vec[NV];
  logic rst_vec[NV];
  int   h_dout[NV];
  int   h_busy[NV];
  int   h_pend[NV];
  int   h_ovf[NV];
  int   h_det[NV];

  task automatic clear_vec();
    for (int c = 0; c < NV; c++) begin
      din_vec[c] = 1'b0;
      rst_vec[c] = 1'b0;
    end
  endtask

  task automatic do_reset(input int sel);
    @(negedge clk);
    if (sel == 0) begin ra = 1'b1; ifa.din = 1'b0; end
    else          begin rb = 1'b1; ifb.din = 1'b0; end
    @(negedge clk);
  endtask

  // Cycle c: record the outputs of cycle c, then drive the inputs for cycle c
  task automatic play(input int sel, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (sel == 0) begin
        h_dout[c] = int'(ifa.dout); h_busy[c] = int'(ifa.busy);
        h_pend[c] = int'(ifa.pending); h_ovf[c] = int'(ifa.overflow);
        h_det[c]  = int'(det);
        ra = rst_vec[c]; ifa.din = din_vec[c];
      end else begin
        h_dout[c] = int'(ifb.dout); h_busy[c] = int'(ifb.busy);
        h_pend[c] = int'(ifb.pending); h_ovf[c] = int'(ifb.overflow);
        h_det[c]  = 0;
        rb = rst_vec[c]; ifb.din = din_vec[c];
      end
    end
  endtask

  initial begin
    int mx, cnt, ev, c, n, ovf0, acc, rises, dets, stray;
    ra = 1'b1; rb = 1'b1; ifa.din = 1'b0; ifb.din = 1'b0;

    // Single event
    clear_vec(); din_vec[10] = 1'b1;
    do_reset(0); play(0, 24);
    chk("single_reset_state", h_dout[0] + h_busy[0] + h_pend[0] + h_ovf[0], 0);
    chk("single_dout10", h_dout[10], 0);
    chk("single_dout11", h_dout[11], 1);
    chk("single_dout14", h_dout[14], 1);
    chk("single_dout15", h_dout[15], 0);
    chk("single_busy16", h_busy[16], 1);
    chk("single_busy17", h_busy[17], 0);
    mx = 0;
    for (int k = 0; k < 24; k++) if (h_pend[k] > mx) mx = h_pend[k];
    chk("single_pend_max", mx, 0);

    // Burst of three
    clear_vec(); din_vec[10] = 1'b1; din_vec[11] = 1'b1; din_vec[12] = 1'b1;
    do_reset(0); play(0, 32);
    chk("burst_pend12", h_pend[12], 1);
    chk("burst_pend13", h_pend[13], 2);
    chk("burst_pend16", h_pend[16], 2);
    chk("burst_pend17", h_pend[17], 1);
    chk("burst_pend22", h_pend[22], 1);
    chk("burst_pend23", h_pend[23], 0);
    chk("burst_dout16", h_dout[16], 0);
    chk("burst_dout17", h_dout[17], 1);
    chk("burst_dout21", h_dout[21], 0);
    chk("burst_dout23", h_dout[23], 1);
    chk("burst_dout26", h_dout[26], 1);
    chk("burst_dout27", h_dout[27], 0);
    chk("burst_busy28", h_busy[28], 1);
    chk("burst_busy29", h_busy[29], 0);

    // Direct consume on the last gap cycle
    clear_vec(); din_vec[10] = 1'b1; din_vec[16] = 1'b1;
    do_reset(0); play(0, 30);
    chk("consume_dout16", h_dout[16], 0);
    chk("consume_dout17", h_dout[17], 1);
    chk("consume_dout21", h_dout[21], 0);
    chk("consume_pend17", h_pend[17], 0);
    chk("consume_ovf17", h_ovf[17], 0);
    cnt = 0;
    for (int k = 11; k <= 22; k++) if (h_busy[k] == 0) cnt++;
    chk("consume_no_idle", cnt, 0);
    chk("consume_busy23", h_busy[23], 0);

    // Saturation with 16-cycle pulses
    clear_vec();
    for (int k = 10; k < 20; k++) din_vec[k] = 1'b1;
    do_reset(1); play(1, 200);
    chk("sat_first_start", h_dout[11], 1);
    chk("sat_pend18", h_pend[18], 7);
    chk("sat_ovf18", h_ovf[18], 0);
    chk("sat_ovf19", h_ovf[19], 1);
    chk("sat_ovf20", h_ovf[20], 1);
    chk("sat_ovf21", h_ovf[21], 0);
    cnt = 0; rises = 0; mx = 0;
    for (int k = 1; k < 200; k++) begin
      if (h_ovf[k] != 0) cnt++;
      if (h_dout[k] != 0 && h_dout[k-1] == 0) rises++;
      if (h_dout[k] != 0) mx++;
    end
    chk("sat_ovf_cycles", cnt, 2);
    chk("sat_pulses", rises, 8);
    chk("sat_high_cycles", mx, 128);

    // Reset mid-operation; din during reset must be ignored
    clear_vec();
    for (int k = 10; k <= 14; k++) din_vec[k] = 1'b1;
    rst_vec[14] = 1'b1;
    do_reset(0); play(0, 40);
    chk("rst_pend14", h_pend[14], 3);
    chk("rst_dout14", h_dout[14], 1);
    chk("rst_dout15", h_dout[15], 0);
    chk("rst_pend15", h_pend[15], 0);
    chk("rst_busy15", h_busy[15], 0);
    cnt = 0;
    for (int k = 15; k < 40; k++) cnt += h_dout[k];
    chk("rst_no_pulses", cnt, 0);

    // Round trip through the edge detector with 200 random events
    clear_vec(); ev = 0; c = 0;
    while (ev < 200 && c < NV - 300) begin
      if ($urandom_range(0, 2) == 0) begin
        din_vec[c] = 1'b1;
        ev++;
      end
      c++;
    end
    n = c + 200;
    do_reset(0);
    ovf0 = m_ovf_cnt[0];
    play(0, n);
    acc = ev - (m_ovf_cnt[0] - ovf0);
    rises = 0; dets = 0; stray = 0;
    for (int k = 2; k < n; k++) begin
      if (h_dout[k-1] != 0 && h_dout[k-2] == 0) rises++;
      if (h_det[k] != 0) begin
        dets++;
        if (!(h_dout[k-1] != 0 && h_dout[k-2] == 0)) stray++;
      end
    end
    chk("rt_events", ev, 200);
    chk("rt_rises", rises, acc);
    chk("rt_detects", dets, acc);
    chk("rt_det_alignment", stray, 0);
    chk("rt_drained", h_busy[n-1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Converts single-cycle event pulses on din into level pulses on dout: each accepted event becomes exactly HIGH_CYCLES cycles high, followed by at least LOW_CYCLES cycles low.
- Events that arrive while an output pulse is in progress are counted in a saturating pending counter and replayed in order.
- This is the generating end of the edge-detect path: feeding dout into the team's rising-edge pulse detector returns exactly one pulse per accepted event.

Parameters:
HIGH_CYCLES, 4, number of cycles dout is held high per event (>=1)
LOW_CYCLES, 2, minimum number of low cycles between consecutive output pulses (>=1, so every output pulse has a distinct rising edge)
PEND_W, 3, width of the pending-event counter; saturates at 2^PEND_W-1

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous, active-high reset
din  input  1  event pulse; each cycle sampled high is one event
dout  output  1  registered stretched level output
busy  output  1  high while state != IDLE
pending  output  PEND_W  number of queued events not yet started
overflow  output  1  single-cycle flag: an event was dropped this cycle

Behaviour:
- Reset (reset=1 at posedge):
  - state=IDLE, dout=0, busy=0, pending=0, overflow=0, internal counter=0.
  - din is ignored while reset is high.
  - Reset during HIGH or GAP: dout drops at that same edge, queued events are discarded, and no further pulses follow.
- All outputs are registered. dout=1 exactly when state==HIGH.
- FSM states: IDLE, HIGH, GAP.
- IDLE:
  - din=1 moves to HIGH at that edge and loads the counter with HIGH_CYCLES-1.
  - dout therefore rises at the edge where din is sampled (visible the cycle after din); latency is 1.
- HIGH:
  - The counter decrements every cycle.
  - When the counter is 0, move to GAP and load LOW_CYCLES-1.
  - dout is high for exactly HIGH_CYCLES cycles.
- GAP:
  - The counter decrements every cycle. When the counter is 0 (last GAP cycle):
    - pending>0: go to HIGH and decrement pending.
    - else if din=1: go to HIGH, consuming din directly.
    - else: go to IDLE.
  - dout is low for exactly LOW_CYCLES cycles between back-to-back pulses; no extra IDLE cycle is inserted.
- din=1 while in HIGH or GAP (other than the direct-consume case above):
  - If pending < 2^PEND_W-1: pending += 1.
  - Otherwise the event is dropped and overflow=1 for that one cycle.
- din=1 on the last GAP cycle with pending>0: one event in, one out, so pending is unchanged, HIGH starts, and no overflow is flagged even if pending is at max.
- Counter width is clog2(max(HIGH_CYCLES, LOW_CYCLES)), minimum 1. The counter never wraps; it is always reloaded on a state change.
- Event conservation invariant (no reset): accepted events = dout rising edges + pending + (1 if an accepted event has not yet started).

Test Plan:
- Single event (defaults): reset, then din=1 only in cycle 10 -> dout=1 in cycles 11-14 and 0 from cycle 15; busy=1 in cycles 11-16; pending stays 0.
- Burst of three: din=1 in cycles 10, 11 and 12 -> dout high in 11-14, 17-20 and 23-26, low in 15-16 and 21-22; pending goes 1, 2 and peaks at 2, then steps to 1 at cycle 17 and 0 at cycle 23; busy drops after cycle 28.
- Boundary consume: with pending=0, din=1 exactly on the last GAP cycle (cycle 16 after a cycle-10 event) -> dout rises again in cycle 17, no IDLE cycle, pending stays 0, overflow=0.
- Saturation (HIGH_CYCLES=16): din held high for 10 cycles from IDLE -> the first event starts immediately, pending reaches 7, overflow=1 for exactly 2 cycles; exactly 8 output pulses result, each 16 high / 2 low.
- Reset mid-operation: with pending=3 in HIGH, assert reset for 1 cycle -> dout=0, pending=0, busy=0 at that edge; no pulses afterwards without new din.
- Round trip: feed 200 random din events into the block, with dout driving the edge-detect block -> detector pulse count equals accepted events (total events minus overflow count), and every detector pulse arrives 1 cycle after a dout rising edge.
